// File: rtl/seg7_bank_if.sv
// Load/status/display bundle between application logic and the seven-segment bank.
interface seg7_bank_if #(
    parameter int NUM_DIGITS = 6,
    parameter int PWM_BITS   = 4
);
    logic                      load;
    logic [5*NUM_DIGITS-1:0]   codes;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blink_en;
    logic                      lz_en;
    logic [PWM_BITS-1:0]       duty;
    logic                      pending;
    logic                      ack;
    logic [8*NUM_DIGITS-1:0]   hex_n;

    modport master (
        output load, codes, dp, blink_en, lz_en, duty,
        input  pending, ack, hex_n
    );
    modport slave (
        input  load, codes, dp, blink_en, lz_en, duty,
        output pending, ack, hex_n
    );
endinterface

// File: rtl/seg7_bank.sv
// Multi-digit active-low seven-segment driver: double-buffered frame-aligned load,
// per-digit blink, leading-zero blanking and PWM brightness.
module seg7_digit (
    input  logic [4:0] code,
    input  logic       dp,
    input  logic       dark,
    input  logic       lz_blank,
    output logic [7:0] hex_n
);
    logic [6:0] seg_n;

    always_comb begin
        seg_n = 7'h7F;
        case (code)
            5'd0:  seg_n = 7'h40;
            5'd1:  seg_n = 7'h79;
            5'd2:  seg_n = 7'h24;
            5'd3:  seg_n = 7'h30;
            5'd4:  seg_n = 7'h19;
            5'd5:  seg_n = 7'h12;
            5'd6:  seg_n = 7'h02;
            5'd7:  seg_n = 7'h78;
            5'd8:  seg_n = 7'h00;
            5'd9:  seg_n = 7'h10;
            5'd10: seg_n = 7'h08;
            5'd11: seg_n = 7'h03;
            5'd12: seg_n = 7'h46;
            5'd13: seg_n = 7'h21;
            5'd14: seg_n = 7'h06;
            5'd15: seg_n = 7'h0E;
            5'd16: seg_n = 7'h3F;
            5'd17: seg_n = 7'h47;
            5'd18: seg_n = 7'h2F;
            default: seg_n = 7'h7F;
        endcase
    end

    // Blink/PWM darkness wins over everything; a blanked leading zero keeps its dp.
    always_comb begin
        hex_n = {~dp, seg_n};
        if (dark)
            hex_n = 8'hFF;
        else if (lz_blank)
            hex_n = {~dp, 7'h7F};
    end
endmodule

module seg7_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int PWM_BITS   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    seg7_bank_if.slave   bus
);
    localparam int BW = $clog2(BLINK_DIV);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][4:0] codes;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blink_en;
        logic                       lz_en;
        logic [PWM_BITS-1:0]        duty;
    } frame_t;

    localparam frame_t FRAME_RST = {{NUM_DIGITS{5'd19}}, {NUM_DIGITS{1'b0}},
                                    {NUM_DIGITS{1'b0}}, 1'b0, {PWM_BITS{1'b1}}};

    frame_t                       in_f, shadow, active;
    logic                         pending_q, ack_q;
    logic [PWM_BITS-1:0]          pwm_cnt;
    logic [BW-1:0]                blink_cnt;
    logic                         blink_phase;
    logic                         frame_end, xfer, pwm_on;
    logic [NUM_DIGITS-1:0]        lead, dark;
    logic [NUM_DIGITS-1:0][7:0]   hex_d, hex_q;

    assign in_f      = {bus.codes, bus.dp, bus.blink_en, bus.lz_en, bus.duty};
    assign frame_end = &pwm_cnt;
    assign xfer      = frame_end & (pending_q | bus.load);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // A load on the boundary cycle goes straight to active and leaves nothing pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow    <= FRAME_RST;
            active    <= FRAME_RST;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= xfer;
            if (bus.load)
                shadow <= in_f;
            if (xfer) begin
                active    <= bus.load ? in_f : shadow;
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign pwm_on = (&active.duty) || (pwm_cnt < active.duty);

    always_comb begin
        logic zrun;
        zrun = active.lz_en;
        lead = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zrun    = zrun & (active.codes[i] == 5'd0);
            lead[i] = zrun;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            dark[i] = ~pwm_on | (active.blink_en[i] & ~blink_phase);
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_digit u_dig (
            .code     (active.codes[g]),
            .dp       (active.dp[g]),
            .dark     (dark[g]),
            .lz_blank (lead[g]),
            .hex_n    (hex_d[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hex_q <= '1;
        else
            hex_q <= hex_d;
    end

    assign bus.hex_n   = hex_q;
    assign bus.pending = pending_q;
    assign bus.ack     = ack_q;
endmodule

// File: tb/tb_seg7_bank.sv
// Self-checking bench for seg7_bank against a cycle-indexed behavioural model.
module tb_seg7_bank;
    localparam int N  = 6;
    localparam int PB = 4;
    localparam int BD = 4;
    localparam int PM = (1 << PB) - 1;

    // Lit (active-high) segment masks for codes 0..18; everything above is blank.
    localparam logic [6:0] LIT [0:18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
        7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h38, 7'h50};

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seg7_bank_if #(.NUM_DIGITS(N), .PWM_BITS(PB)) bus ();

    seg7_bank #(.NUM_DIGITS(N), .BLINK_DIV(BD), .PWM_BITS(PB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: k = clock edges since reset release; a_* active, s_* shadow.
    int               k;
    bit               m_pend;
    logic [5*N-1:0]   a_codes, s_codes;
    logic [N-1:0]     a_dp, s_dp, a_blink, s_blink;
    logic             a_lz, s_lz;
    logic [PB-1:0]    a_duty, s_duty;
    logic [8*N-1:0]   exp_hex;
    logic             exp_ack, exp_pend;

    task automatic model_reset();
        k = 0; m_pend = 0;
        a_codes = {N{5'd19}}; a_dp = '0; a_blink = '0; a_lz = 0; a_duty = '1;
        s_codes = a_codes; s_dp = '0; s_blink = '0; s_lz = 0; s_duty = '1;
        exp_hex = '1; exp_ack = 0; exp_pend = 0;
    endtask

    function automatic logic [7:0] ref_digit(int i, int pwm, bit ph);
        logic [4:0] c;
        int hi;
        bit on, lzb;
        c  = a_codes[5*i +: 5];
        hi = -1;
        for (int j = 0; j < N; j++)
            if (a_codes[5*j +: 5] != 5'd0) hi = j;
        lzb = a_lz && (i > 0) && (i > hi);
        on  = (int'(a_duty) == PM) || (pwm < int'(a_duty));
        if (!on || (a_blink[i] && !ph)) return 8'hFF;
        if (lzb) return {~a_dp[i], 7'h7F};
        return {~a_dp[i], (int'(c) < 19) ? ~LIT[c] : 7'h7F};
    endfunction

    task automatic step();
        int pwm;
        bit ph, fr;
        @(posedge clk);
        pwm = k % (PM + 1);
        ph  = ((k / BD) % 2) == 0;
        fr  = (pwm == PM);
        for (int i = 0; i < N; i++) exp_hex[8*i +: 8] = ref_digit(i, pwm, ph);
        exp_ack = fr && (m_pend || bus.load);
        if (bus.load) begin
            s_codes = bus.codes; s_dp = bus.dp; s_blink = bus.blink_en;
            s_lz = bus.lz_en; s_duty = bus.duty;
        end
        if (exp_ack) begin
            a_codes = s_codes; a_dp = s_dp; a_blink = s_blink; a_lz = s_lz; a_duty = s_duty;
            m_pend = 0;
        end else if (bus.load) begin
            m_pend = 1;
        end
        exp_pend = m_pend;
        k++;
        #1;
    endtask

    task automatic align(int ph);
        for (int n = 0; n < 2 * (PM + 1) && (k % (PM + 1)) != ph; n++) step();
    endtask

    task automatic drive(logic [5*N-1:0] c, logic [N-1:0] d, logic [N-1:0] b, logic lz,
                         logic [PB-1:0] du);
        bus.codes = c; bus.dp = d; bus.blink_en = b; bus.lz_en = lz; bus.duty = du;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        int acks;
        acks = 0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.hex_n !== '1 || bus.pending !== 1'b0 || bus.ack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: hex=%h pend=%b ack=%b want hex=ff.. pend=0 ack=0",
                     bus.hex_n, bus.pending, bus.ack);
        end
        reset_n = 1'b1;
        repeat (5) step();
        drive({N{5'd8}}, '1, '0, 1'b0, 4'd15);
        repeat (3) step();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.hex_n !== '1 || bus.pending !== 1'b0 || bus.ack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: hex=%h pend=%b ack=%b want all ones/0/0",
                     bus.hex_n, bus.pending, bus.ack);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 2 * (PM + 1) + 2; n++) begin
            step();
            if (bus.ack === 1'b1) acks++;
            n_cmp++;
            if (bus.hex_n !== exp_hex || bus.ack !== exp_ack || bus.pending !== exp_pend) begin
                n_bad++;
                $display("FAIL reset_after cyc %0d: hex=%h ack=%b pend=%b want %h %b %b",
                         n, bus.hex_n, bus.ack, bus.pending, exp_hex, exp_ack, exp_pend);
            end
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL reset_no_ack: acks=%0d want 0", acks);
        end
    endtask

    task automatic test_basic();
        int pend_cyc, acks;
        pend_cyc = 0; acks = 0;
        align(3);
        drive({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, '0, '0, 1'b0, 4'd15);
        if (bus.pending === 1'b1) pend_cyc++;
        for (int n = 0; n < 20; n++) begin
            step();
            if (bus.pending === 1'b1) pend_cyc++;
            if (bus.ack === 1'b1) acks++;
            n_cmp++;
            if (bus.hex_n !== exp_hex || bus.ack !== exp_ack || bus.pending !== exp_pend) begin
                n_bad++;
                $display("FAIL basic cyc %0d: hex=%h ack=%b pend=%b want %h %b %b",
                         n, bus.hex_n, bus.ack, bus.pending, exp_hex, exp_ack, exp_pend);
            end
        end
        n_cmp++;
        if (pend_cyc != 12 || acks != 1) begin
            n_bad++;
            $display("FAIL basic_timing: pending cycles=%0d acks=%0d want 12 and 1", pend_cyc, acks);
        end
        n_cmp++;
        if (bus.hex_n[7:0] !== 8'hC0 || bus.hex_n[47:40] !== 8'h92) begin
            n_bad++;
            $display("FAIL basic_digits: d0=%h d5=%h want c0 92", bus.hex_n[7:0], bus.hex_n[47:40]);
        end
    endtask

    task automatic test_double_load();
        int acks, seen_a;
        acks = 0; seen_a = 0;
        align(2);
        drive({N{5'd8}}, '0, '0, 1'b0, 4'd15);
        repeat (5) step();
        drive({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, '0, '0, 1'b0, 4'd15);
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.ack === 1'b1) acks++;
            if (bus.hex_n[7:0] === 8'h80) seen_a++;
            n_cmp++;
            if (bus.hex_n !== exp_hex || bus.ack !== exp_ack || bus.pending !== exp_pend) begin
                n_bad++;
                $display("FAIL double cyc %0d: hex=%h ack=%b pend=%b want %h %b %b",
                         n, bus.hex_n, bus.ack, bus.pending, exp_hex, exp_ack, exp_pend);
            end
        end
        n_cmp++;
        if (acks != 1 || seen_a != 0) begin
            n_bad++;
            $display("FAIL double_once: acks=%0d A-frames=%0d want 1 and 0", acks, seen_a);
        end
        n_cmp++;
        if (bus.hex_n[7:0] !== 8'hF9 || bus.hex_n[47:40] !== 8'h82) begin
            n_bad++;
            $display("FAIL double_latest: d0=%h d5=%h want f9 82", bus.hex_n[7:0], bus.hex_n[47:40]);
        end
    endtask

    task automatic test_lz();
        logic [8*N-1:0] want;
        want = {8'hFF, 8'h7F, 8'hFF, 8'hF8, 8'hC0, 8'hC0};
        drive({5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0}, 6'b010000, '0, 1'b1, 4'd15);
        repeat (PM + 3) step();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (bus.hex_n[8*i +: 8] !== want[8*i +: 8]) begin
                n_bad++;
                $display("FAIL lz_digit%0d: got %h want %h", i, bus.hex_n[8*i +: 8], want[8*i +: 8]);
            end
        end
    endtask

    task automatic test_blink();
        int dark0, other_chg;
        logic [8*N-1:8] first;
        dark0 = 0; other_chg = 0;
        drive({5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, '0, 6'b000001, 1'b0, 4'd15);
        repeat (PM + 3) step();
        first = bus.hex_n[8*N-1:8];
        for (int n = 0; n < 32; n++) begin
            step();
            if (bus.hex_n[7:0] === 8'hFF) dark0++;
            if (bus.hex_n[8*N-1:8] !== first) other_chg++;
            n_cmp++;
            if (bus.hex_n !== exp_hex) begin
                n_bad++;
                $display("FAIL blink cyc %0d: hex=%h want %h", n, bus.hex_n, exp_hex);
            end
        end
        n_cmp++;
        if (dark0 != 16 || other_chg != 0) begin
            n_bad++;
            $display("FAIL blink_ratio: dark=%0d changes=%0d want 16 and 0", dark0, other_chg);
        end
    endtask

    task automatic test_pwm();
        int on_c, off_c;
        on_c = 0; off_c = 0;
        drive({{(N-1){5'd19}}, 5'd8}, '0, '0, 1'b0, 4'd4);
        repeat (PM + 3) step();
        for (int n = 0; n < PM + 1; n++) begin
            step();
            if (bus.hex_n[6:0] === 7'h00) on_c++;
            if (bus.hex_n[7:0] === 8'hFF) off_c++;
        end
        n_cmp++;
        if (on_c != 4 || off_c != 12) begin
            n_bad++;
            $display("FAIL pwm_duty4: on=%0d off=%0d want 4 and 12", on_c, off_c);
        end
        off_c = 0;
        drive({{(N-1){5'd19}}, 5'd8}, '0, '0, 1'b0, 4'd0);
        repeat (PM + 3) step();
        for (int n = 0; n < PM + 1; n++) begin
            step();
            if (bus.hex_n[7:0] === 8'hFF) off_c++;
        end
        n_cmp++;
        if (off_c != PM + 1) begin
            n_bad++;
            $display("FAIL pwm_duty0: off=%0d want %0d", off_c, PM + 1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < N; i++)
                    bus.codes[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bus.dp = N'($urandom); bus.blink_en = N'($urandom);
                bus.lz_en = 1'($urandom); bus.duty = PB'($urandom);
                bus.load = 1'b1;
            end
            step();
            bus.load = 1'b0;
            n_cmp++;
            if (bus.hex_n !== exp_hex || bus.ack !== exp_ack || bus.pending !== exp_pend) begin
                n_bad++;
                $display("FAIL random cyc %0d: hex=%h ack=%b pend=%b want %h %b %b",
                         n, bus.hex_n, bus.ack, bus.pending, exp_hex, exp_ack, exp_pend);
            end
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.codes = '0; bus.dp = '0; bus.blink_en = '0;
        bus.lz_en = 1'b0; bus.duty = '1;
        test_reset();
        test_basic();
        test_double_load();
        test_lz();
        test_blink();
        test_pwm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
